// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters and the register-file write port.
// The master side belongs to the requesters and the register file. The slave side belongs to the arbiter.
interface regfile_wb_arbiter_if;
  // Handshake: each requester holds Req/Addr/Data stable until the cycle its Grant is high.
  // The transfer completes in that cycle, and a new item may be presented on the next cycle.
  logic        Req0;
  logic [4:0]  Addr0;
  logic [31:0] Data0;
  logic        Grant0;

  logic        Req1;
  logic [4:0]  Addr1;
  logic [31:0] Data1;
  logic        Grant1;

  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        Forced;

  modport master (
    output Req0, Addr0, Data0,
    output Req1, Addr1, Data1,
    input  Grant0, Grant1,
    input  RegWrite, WriteAddr, WriteData, Forced
  );

  modport slave (
    input  Req0, Addr0, Data0,
    input  Req1, Addr1, Data1,
    output Grant0, Grant1,
    output RegWrite, WriteAddr, WriteData, Forced
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU (high priority)
// and the load/mul-div path (low priority, starvation guarded); registered write stage.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } arbState_t;

  localparam logic [CNT_W-1:0] LastDenial = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(STARVE_LIMIT);

  arbState_t        state;
  logic [CNT_W-1:0] starveCnt;
  logic             forcedQ;

  logic        grant0;
  logic        grant1;
  logic        regWriteQ;
  logic [4:0]  writeAddrQ;
  logic [31:0] writeDataQ;

  // Grants are the only combinational outputs. They are suppressed during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!Reset) begin
      if (state == FORCE1) begin
        grant1 = bus.Req1;
        grant0 = bus.Req0 & ~bus.Req1;
      end else begin
        grant0 = bus.Req0;
        grant1 = bus.Req1 & ~bus.Req0;
      end
    end
  end

  // Arbitration FSM with starvation counter.
  // FORCE1 always lasts a single cycle, because either Req1 is granted or it has withdrawn.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= PRIO0;
      starveCnt <= '0;
      forcedQ   <= 1'b0;
    end else begin
      case (state)
        PRIO0: begin
          if (bus.Req1 && !grant1) begin
            if (starveCnt == LastDenial) begin
              state     <= FORCE1;
              starveCnt <= '0;
              forcedQ   <= 1'b1;
            end else if (starveCnt < CntMax) begin
              starveCnt <= starveCnt + 1'b1;
            end
          end else begin
            starveCnt <= '0;
          end
        end
        FORCE1: begin
          starveCnt <= '0;
          if (grant1 || !bus.Req1) begin
            state   <= PRIO0;
            forcedQ <= 1'b0;
          end
        end
        default: begin
          state     <= PRIO0;
          starveCnt <= '0;
          forcedQ   <= 1'b0;
        end
      endcase
    end
  end

  // Output stage.
  // Writes to r0 are consumed without touching the write port, so the address and data hold their previous values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      regWriteQ  <= 1'b0;
      writeAddrQ <= '0;
      writeDataQ <= '0;
    end else begin
      regWriteQ <= 1'b0;
      if (grant0 && (bus.Addr0 != 5'd0)) begin
        regWriteQ  <= 1'b1;
        writeAddrQ <= bus.Addr0;
        writeDataQ <= bus.Data0;
      end else if (grant1 && (bus.Addr1 != 5'd0)) begin
        regWriteQ  <= 1'b1;
        writeAddrQ <= bus.Addr1;
        writeDataQ <= bus.Data1;
      end
    end
  end

  assign bus.Grant0    = grant0;
  assign bus.Grant1    = grant1;
  assign bus.RegWrite  = regWriteQ;
  assign bus.WriteAddr = writeAddrQ;
  assign bus.WriteData = writeDataQ;
  assign bus.Forced    = forcedQ;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations (STARVE_LIMIT=4).
module tb_regfile_wb_arbiter;

  logic Clock;
  logic Reset;
  int   checkCount;
  int   errorCount;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive0(input logic req, input logic [4:0] addr, input logic [31:0] data);
    bus.Req0  = req;
    bus.Addr0 = addr;
    bus.Data0 = data;
  endtask

  task automatic drive1(input logic req, input logic [4:0] addr, input logic [31:0] data);
    bus.Req1  = req;
    bus.Addr1 = addr;
    bus.Data1 = data;
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data);
    check_val({tag, "_we"},   32'(bus.RegWrite),  32'(we));
    check_val({tag, "_addr"}, 32'(bus.WriteAddr), 32'(addr));
    check_val({tag, "_data"}, bus.WriteData,      data);
  endtask

  task automatic check_grants(input string tag, input logic g0, input logic g1, input logic forced);
    #1;
    check_val({tag, "_g0"},     32'(bus.Grant0), 32'(g0));
    check_val({tag, "_g1"},     32'(bus.Grant1), 32'(g1));
    check_val({tag, "_forced"}, 32'(bus.Forced), 32'(forced));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    Reset = 1'b1;
    drive0(1'b1, 5'd5, 32'h5555_5555);
    drive1(1'b1, 5'd6, 32'h6666_6666);

    // Reset state: outputs cleared, and grants are blocked while Reset is high.
    tick();
    tick();
    check_out("rst", 1'b0, 5'd0, 32'd0);
    check_grants("rst", 1'b0, 1'b0, 1'b0);

    // A single ALU write.
    Reset = 1'b0;
    drive1(1'b0, 5'd0, 32'd0);
    drive0(1'b1, 5'd5, 32'hDEAD_BEEF);
    check_grants("alu", 1'b1, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_out("alu_wr", 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check_out("alu_idle", 1'b0, 5'd5, 32'hDEAD_BEEF);

    // Same destination: r0 wins first, then r1 writes later, so the last grant wins.
    drive0(1'b1, 5'd3, 32'hA0A0_A0A0);
    drive1(1'b1, 5'd3, 32'hB1B1_B1B1);
    check_grants("same", 1'b1, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_out("same_w0", 1'b1, 5'd3, 32'hA0A0_A0A0);
    check_grants("same_r1", 1'b0, 1'b1, 1'b0);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    check_out("same_w1", 1'b1, 5'd3, 32'hB1B1_B1B1);
    tick();

    // Starvation: four denials, then a forced grant to r1, then back to PRIO0.
    drive0(1'b1, 5'd7, 32'h0000_0011);
    drive1(1'b1, 5'd9, 32'h0000_0022);
    for (int i = 0; i < 4; i++) begin
      check_grants($sformatf("starve%0d", i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_grants("force", 1'b0, 1'b1, 1'b1);
    check_out("force_prev", 1'b1, 5'd7, 32'h0000_0011);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    check_out("force_wr", 1'b1, 5'd9, 32'h0000_0022);
    check_grants("unforce", 1'b1, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_out("unforce_wr", 1'b1, 5'd7, 32'h0000_0011);
    tick();

    // A write to r0 is granted but suppressed, and the address and data hold their previous values.
    drive1(1'b1, 5'd0, 32'h0000_1234);
    check_grants("r0", 1'b0, 1'b1, 1'b0);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    check_out("r0_wr", 1'b0, 5'd7, 32'h0000_0011);
    tick();

    // Requester 1 withdraws while in FORCE1.
    drive0(1'b1, 5'd4, 32'h0000_0044);
    drive1(1'b1, 5'd6, 32'h0000_0066);
    for (int i = 0; i < 4; i++) tick();
    drive1(1'b0, 5'd0, 32'd0);
    check_grants("withdraw", 1'b1, 1'b0, 1'b1);
    tick();
    drive0(1'b1, 5'd8, 32'h0000_0088);
    check_out("withdraw_wr", 1'b1, 5'd4, 32'h0000_0044);
    check_grants("withdraw_back", 1'b1, 1'b0, 1'b0);
    // After returning to PRIO0 the counter starts from zero, so a new r1 request needs four denials again.
    drive1(1'b1, 5'd10, 32'h0000_00AA);
    for (int i = 0; i < 4; i++) begin
      check_grants($sformatf("recount%0d", i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_grants("reforce", 1'b0, 1'b1, 1'b1);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    check_out("reforce_wr", 1'b1, 5'd10, 32'h0000_00AA);

    // Reset during a pending grant discards the winner.
    drive0(1'b1, 5'd12, 32'h0000_CAFE);
    Reset = 1'b1;
    check_grants("rst_mid", 1'b0, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
    drive0(1'b0, 5'd0, 32'd0);
    check_out("rst_mid_out", 1'b0, 5'd0, 32'd0);
    check_grants("rst_mid_idle", 1'b0, 1'b0, 1'b0);

    // The requester re-presents its item after reset.
    drive0(1'b1, 5'd12, 32'h0000_CAFE);
    check_grants("rst_retry", 1'b1, 1'b0, 1'b0);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_out("rst_retry_wr", 1'b1, 5'd12, 32'h0000_CAFE);
    tick();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
